glip_uart_control_ingress: RTL and testbench
============================================

Name: glip_uart_control_ingress

Overview:
- Receive-side decoder of the UART control stream.
- Sits between the UART receive module and the ingress FIFO.
- Strips the 0xfe escape (0xfe 0xfe decodes to one 0xfe data byte).
- Extracts 3-byte credit messages (0xfe, {credit[14:8],1}, credit[7:0]) and presents each as a 15-bit credit with a one-cycle strobe.
- All other bytes pass through to the FIFO.

Parameters:
none

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
in_data  input  8  received byte from UART receive module
in_valid  input  1  one-cycle strobe, in_data valid; no backpressure possible
out_data  output  8  decoded user byte to ingress FIFO
out_enable  output  1  one-cycle FIFO write strobe
out_ready  input  1  FIFO not full; sampled in the in_valid cycle
credit  output  15  received credit value, held until next credit message
credit_en  output  1  one-cycle strobe, credit updated
error  output  1  one-cycle pulse on protocol violation or overflow

Behaviour:
- Clock and reset: single clock domain. rst is synchronous and active-high; it is sampled on posedge clk.
- Reset values: state=STATE_PASSTHROUGH, out_data=0, out_enable=0, credit=0, credit_en=0, error=0.
  - Reset mid-message discards the partial escape or credit; no credit_en is generated.
- Registered outputs: out_data, out_enable, credit, credit_en and error are all registered.
  - Latency is exactly 1 cycle from the in_valid cycle of the deciding byte.
- Pulse rules: out_enable, credit_en and error are single-cycle pulses. They are 0 in every cycle not following an accepted in_valid.
- Throughput: in_valid may be asserted every cycle (back-to-back bytes). Each byte is consumed in its valid cycle.
- No-input cycles: bytes only advance the FSM when in_valid=1. Idle cycles do not change state.
- STATE_PASSTHROUGH:
  - in_data!=0xfe: write the byte (out_data=in_data, out_enable=1 next cycle). Stay in this state.
  - in_data==0xfe: nothing written. Go to STATE_ESCAPE.
- STATE_ESCAPE (decision order is fixed):
  - in_data==0xfe: write 0xfe. Go to STATE_PASSTHROUGH.
  - else in_data[0]==1: latch credit_hi=in_data[7:1]. Go to STATE_CREDIT.
  - else (bit0=0, not 0xfe): error=1 next cycle, byte dropped. Go to STATE_PASSTHROUGH.
- STATE_CREDIT:
  - Any byte: credit<={credit_hi,in_data} and credit_en=1 next cycle. Go to STATE_PASSTHROUGH.
  - A low byte of 0xfe is payload here, not an escape.
- Overflow: if a data write is due (either write case above) while out_ready=0:
  - The byte is dropped, out_enable stays 0 and error=1 next cycle.
  - The state transition proceeds as if the write had happened.
- Credit strobes: credit messages never depend on out_ready.
- Simultaneous events: credit_en and out_enable are never asserted in the same cycle, since one byte produces at most one action. error may only coincide with neither.
- Credit value: unsigned 15-bit, MSB-first as defined above. All 15-bit values are legal, including 0 and 0x7fff.

Test Plan:
- Data bytes 0x00, 0x41, 0xff with out_ready=1 -> three out_enable pulses, one cycle after each in_valid, with out_data 0x00, 0x41, 0xff. No credit_en, no error.
- Bytes 0xfe, 0xfe, 0x12 -> exactly two writes, 0xfe then 0x12. The first 0xfe produces no write.
- Bytes 0xfe, 0x03, 0x04 -> credit=0x0104 and credit_en one cycle after the third byte; no out_enable. Also 0xfe, 0xff, 0xfe -> credit=0x7ffe.
- Back-to-back every-cycle stream 0x55, 0xfe, 0xab, 0xcd, 0xfe, 0xfe -> write 0x55, credit_en with credit=0x55cd, then write 0xfe. Outputs remain 1-cycle latency.
- Bytes 0xfe, 0x10 -> error pulse, no write; then 0x20 -> written normally (state back in passthrough).
- Overflow: 0x33 with out_ready=0 -> no out_enable, error pulse. Next 0x34 with out_ready=1 -> written.
- Reset mid-message: rst asserted after 0xfe, 0x03 -> no credit_en. A following 0x04 is written as data.

Source files
------------

// File: rtl/glip_uart_control_ingress_if.sv
// rtl/glip_uart_control_ingress_if.sv - byte/credit bus between UART receiver, control decoder and ingress FIFO
interface glip_uart_control_ingress_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic [7:0]  out_data;
  logic        out_enable;
  logic        out_ready;
  logic [14:0] credit;
  logic        credit_en;
  logic        error;

  // Producer side: UART receiver bytes in, FIFO status in, decoded results observed
  modport master (
    output in_data,
    output in_valid,
    output out_ready,
    input  out_data,
    input  out_enable,
    input  credit,
    input  credit_en,
    input  error
  );

  // Decoder side
  modport slave (
    input  in_data,
    input  in_valid,
    input  out_ready,
    output out_data,
    output out_enable,
    output credit,
    output credit_en,
    output error
  );
endinterface

// File: rtl/glip_uart_control_ingress.sv
// rtl/glip_uart_control_ingress.sv - UART control-stream decoder: escape stripping and credit extraction
module glip_uart_control_ingress (
  input  logic                          clk,
  input  logic                          rst,
  glip_uart_control_ingress_if.slave    bus
);

  localparam logic [7:0] ESC_BYTE = 8'hfe;

  typedef enum logic [1:0] {
    STATE_PASSTHROUGH = 2'd0,
    STATE_ESCAPE      = 2'd1,
    STATE_CREDIT      = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [7:0]  r_out_data;
  logic        r_out_enable;
  logic [14:0] r_credit;
  logic        r_credit_en;
  logic        r_error;
  logic [6:0]  r_credit_hi;

  logic [7:0]  w_out_data;
  logic        w_out_enable;
  logic [14:0] w_credit;
  logic        w_credit_en;
  logic        w_error;
  logic [6:0]  w_credit_hi;
  logic        w_write_due;

  // State and registered outputs; reset drops any half-received escape or credit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= STATE_PASSTHROUGH;
      r_out_data   <= 8'h00;
      r_out_enable <= 1'b0;
      r_credit     <= 15'h0000;
      r_credit_en  <= 1'b0;
      r_error      <= 1'b0;
      r_credit_hi  <= 7'h00;
    end else begin
      r_state      <= w_state_next;
      r_out_data   <= w_out_data;
      r_out_enable <= w_out_enable;
      r_credit     <= w_credit;
      r_credit_en  <= w_credit_en;
      r_error      <= w_error;
      r_credit_hi  <= w_credit_hi;
    end
  end

  // Next state: only a valid byte advances the decoder
  always_comb begin
    w_state_next = r_state;
    if (bus.in_valid) begin
      case (r_state)
        STATE_PASSTHROUGH: begin
          if (bus.in_data == ESC_BYTE) w_state_next = STATE_ESCAPE;
          else                         w_state_next = STATE_PASSTHROUGH;
        end
        STATE_ESCAPE: begin
          if (bus.in_data == ESC_BYTE) w_state_next = STATE_PASSTHROUGH;
          else if (bus.in_data[0])     w_state_next = STATE_CREDIT;
          else                         w_state_next = STATE_PASSTHROUGH;
        end
        STATE_CREDIT: w_state_next = STATE_PASSTHROUGH;
        default:      w_state_next = STATE_PASSTHROUGH;
      endcase
    end
  end

  // Output decisions; a data write blocked by a full FIFO becomes an error pulse instead
  always_comb begin
    w_out_data   = r_out_data;
    w_out_enable = 1'b0;
    w_credit     = r_credit;
    w_credit_en  = 1'b0;
    w_error      = 1'b0;
    w_credit_hi  = r_credit_hi;
    w_write_due  = 1'b0;
    if (bus.in_valid) begin
      case (r_state)
        STATE_PASSTHROUGH: begin
          if (bus.in_data != ESC_BYTE) w_write_due = 1'b1;
        end
        STATE_ESCAPE: begin
          if (bus.in_data == ESC_BYTE) w_write_due = 1'b1;
          else if (bus.in_data[0])     w_credit_hi = bus.in_data[7:1];
          else                         w_error     = 1'b1;
        end
        STATE_CREDIT: begin
          // The low byte is raw payload, 0xfe included
          w_credit    = {r_credit_hi, bus.in_data};
          w_credit_en = 1'b1;
        end
        default: ;
      endcase
      if (w_write_due) begin
        if (bus.out_ready) begin
          w_out_data   = bus.in_data;
          w_out_enable = 1'b1;
        end else begin
          w_error = 1'b1;
        end
      end
    end
  end

  assign bus.out_data   = r_out_data;
  assign bus.out_enable = r_out_enable;
  assign bus.credit     = r_credit;
  assign bus.credit_en  = r_credit_en;
  assign bus.error      = r_error;

endmodule

// File: tb/tb_glip_uart_control_ingress.sv
// tb/tb_glip_uart_control_ingress.sv - directed self-checking bench for glip_uart_control_ingress
module tb_glip_uart_control_ingress;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_passed;
  logic [14:0] exp_credit;

  glip_uart_control_ingress_if u_if ();

  glip_uart_control_ingress u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of input, then sample 1 time unit after the capturing edge
  task automatic cyc(input logic v, input logic [7:0] d, input logic rdy);
    u_if.in_valid  = v;
    u_if.in_data   = d;
    u_if.out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
  endtask

  task automatic chk_val(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    n_checks++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Check the outputs produced by the byte of the previous cycle
  task automatic chk(input string tag, input logic en, input logic [7:0] data,
                     input logic cen, input logic err);
    chk_bit({tag, ".out_enable"}, u_if.out_enable, en);
    if (en) chk_val({tag, ".out_data"}, {7'h0, u_if.out_data}, {7'h0, data});
    chk_bit({tag, ".credit_en"}, u_if.credit_en, cen);
    chk_val({tag, ".credit"}, u_if.credit, exp_credit);
    chk_bit({tag, ".error"}, u_if.error, err);
  endtask

  initial begin
    n_checks       = 0;
    n_passed       = 0;
    exp_credit     = 15'h0;
    u_if.in_valid  = 1'b0;
    u_if.in_data   = 8'h00;
    u_if.out_ready = 1'b1;

    // Reset state
    rst = 1'b1;
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("reset", 1'b0, 8'h00, 1'b0, 1'b0);
    chk_val("reset.out_data", {7'h0, u_if.out_data}, 15'h0);
    rst = 1'b0;
    cyc(1'b0, 8'h00, 1'b1);
    chk("idle0", 1'b0, 8'h00, 1'b0, 1'b0);

    // Plain data bytes
    cyc(1'b1, 8'h00, 1'b1); chk("d00", 1'b1, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 8'h41, 1'b1); chk("d41", 1'b1, 8'h41, 1'b0, 1'b0);
    cyc(1'b1, 8'hff, 1'b1); chk("dff", 1'b1, 8'hff, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1); chk("idle1", 1'b0, 8'h00, 1'b0, 1'b0);

    // Escaped 0xfe
    cyc(1'b1, 8'hfe, 1'b1); chk("esc_a", 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 8'hfe, 1'b1); chk("esc_b", 1'b1, 8'hfe, 1'b0, 1'b0);
    cyc(1'b1, 8'h12, 1'b1); chk("esc_c", 1'b1, 8'h12, 1'b0, 1'b0);

    // Credit 0x0104
    cyc(1'b1, 8'hfe, 1'b1); chk("cr1_a", 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 8'h03, 1'b1); chk("cr1_b", 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 8'h04, 1'b1); exp_credit = 15'h0104;
    chk("cr1_c", 1'b0, 8'h00, 1'b1, 1'b0);

    // Credit 0x7ffe, low byte 0xfe is payload
    cyc(1'b1, 8'hfe, 1'b1); chk("cr2_a", 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 8'hff, 1'b1); chk("cr2_b", 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 8'hfe, 1'b1); exp_credit = 15'h7ffe;
    chk("cr2_c", 1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1); chk("cr_hold", 1'b0, 8'h00, 1'b0, 1'b0);

    // Back-to-back mixed stream
    cyc(1'b1, 8'h55, 1'b1); chk("b2b_55", 1'b1, 8'h55, 1'b0, 1'b0);
    cyc(1'b1, 8'hfe, 1'b1); chk("b2b_fe", 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 8'hab, 1'b1); chk("b2b_ab", 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 8'hcd, 1'b1); exp_credit = 15'h55cd;
    chk("b2b_cd", 1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 8'hfe, 1'b1); chk("b2b_fe2", 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 8'hfe, 1'b1); chk("b2b_fe3", 1'b1, 8'hfe, 1'b0, 1'b0);

    // Protocol error after escape, then recovery
    cyc(1'b1, 8'hfe, 1'b1); chk("perr_a", 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 8'h10, 1'b1); chk("perr_b", 1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 8'h20, 1'b1); chk("perr_c", 1'b1, 8'h20, 1'b0, 1'b0);

    // Overflow on plain data and on escaped data
    cyc(1'b1, 8'h33, 1'b0); chk("ovf_a", 1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 8'h34, 1'b1); chk("ovf_b", 1'b1, 8'h34, 1'b0, 1'b0);
    cyc(1'b1, 8'hfe, 1'b0); chk("ovf_c", 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 8'hfe, 1'b0); chk("ovf_d", 1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 8'h35, 1'b1); chk("ovf_e", 1'b1, 8'h35, 1'b0, 1'b0);

    // Credit of zero with FIFO full: independent of out_ready
    cyc(1'b1, 8'hfe, 1'b0); chk("cr0_a", 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 8'h01, 1'b0); chk("cr0_b", 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 8'h00, 1'b0); exp_credit = 15'h0000;
    chk("cr0_c", 1'b0, 8'h00, 1'b1, 1'b0);

    // Idle cycle inside an escape keeps the state
    cyc(1'b1, 8'hfe, 1'b1); chk("idle_esc_a", 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 8'hfe, 1'b1); chk("idle_esc_b", 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 8'hfe, 1'b1); chk("idle_esc_c", 1'b1, 8'hfe, 1'b0, 1'b0);

    // Reset in the middle of a credit message
    cyc(1'b1, 8'hfe, 1'b1); chk("rstm_a", 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 8'h03, 1'b1); chk("rstm_b", 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 8'h7e, 1'b1); exp_credit = 15'h017e;
    chk("rstm_pre", 1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 8'hfe, 1'b1); chk("rstm_c", 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 8'h03, 1'b1); chk("rstm_d", 1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    cyc(1'b0, 8'h00, 1'b1); exp_credit = 15'h0000;
    chk("rstm_rst", 1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    cyc(1'b1, 8'h04, 1'b1); chk("rstm_e", 1'b1, 8'h04, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1); chk("rstm_f", 1'b0, 8'h00, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end
endmodule
